call_stack_unit: RTL

Parametrised multi-cycle stack sequencer for CALL, RET, PUSH and POP. It sits between the instruction decoder and the data RAM port and owns the stack pointer. It spills and fills return addresses one byte per cycle, returns branch targets to the fetcher, and flags stack overflow/underflow instead of corrupting memory.

---
 rtl/call_stack_unit.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/call_stack_unit.sv
// call_stack_unit: multi-cycle CALL/RET/PUSH/POP sequencer that owns the
// stack pointer and moves return addresses to/from RAM one word per cycle.
// The stack grows upward and SP points at the last written word.
module call_stack_unit #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 16,
    parameter int                PC_W        = 16,
    parameter logic [ADDR_W-1:0] STACK_BASE  = 16'hFF00,
    parameter int                STACK_DEPTH = 256
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [PC_W-1:0]   target_i,
    input  logic [PC_W-1:0]   pc_i,
    input  logic [DATA_W-1:0] push_data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pc_load_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [DATA_W-1:0] pop_data_o,
    output logic              fault_o,
    output logic [1:0]        fault_code_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_we_o,
    output logic              mem_re_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [ADDR_W-1:0] sp_o
);
    localparam int BYTES = PC_W / DATA_W;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES + 1) : 1;
    localparam logic [ADDR_W-1:0] SP_EMPTY = ADDR_W'(STACK_BASE - 1);
    localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(STACK_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE, S_FAULT
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;     // words left after the current one
    logic              single_q, single_d; // PUSH/POP (one word) vs CALL/RET
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic [PC_W-1:0]   wsh_q, wsh_d;     // remaining return-address words to spill
    logic [PC_W-1:0]   asm_q, asm_d;     // return-address assembly register
    logic              rd_pend_q;        // a read strobe was issued last cycle

    logic              done_q, done_d, pcload_q, pcload_d, fault_q, fault_d;
    logic [1:0]        fcode_q, fcode_d;
    logic [PC_W-1:0]   pc_out_q, pc_out_d;
    logic [DATA_W-1:0] pop_q, pop_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d, re_q, re_d;

    logic [ADDR_W:0]   count, need;

    assign count = {1'b0, sp_q} - {1'b0, SP_EMPTY};
    assign need  = op_i[1] ? (ADDR_W+1)'(1) : (ADDR_W+1)'(BYTES);

    // Next-state and next-output logic; strobes are computed one cycle ahead
    // so they leave the block straight from flops.
    always_comb begin
        state_d  = state_q;
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        single_d = single_q;
        tgt_d    = tgt_q;
        wsh_d    = wsh_q;
        asm_d    = rd_pend_q ? PC_W'({asm_q, mem_rdata_i}) : asm_q;
        done_d   = 1'b0;
        pcload_d = 1'b0;
        fault_d  = 1'b0;
        fcode_d  = 2'b00;
        we_d     = 1'b0;
        re_d     = 1'b0;
        pc_out_d = pc_out_q;
        pop_d    = pop_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    single_d = op_i[1];
                    tgt_d    = target_i;
                    cnt_d    = op_i[1] ? '0 : CNT_W'(BYTES - 1);
                    if (!op_i[0]) begin
                        // CALL / PUSH
                        if (count + need > DEPTH_C) begin
                            state_d = S_FAULT;
                            done_d  = 1'b1;
                            fault_d = 1'b1;
                            fcode_d = 2'b01;
                        end else begin
                            state_d = S_WRITE;
                            we_d    = 1'b1;
                            addr_d  = sp_q + ADDR_W'(1);
                            wdata_d = op_i[1] ? push_data_i : pc_i[DATA_W-1:0];
                            wsh_d   = pc_i >> DATA_W;
                        end
                    end else begin
                        // RET / POP
                        if (count < need) begin
                            state_d = S_FAULT;
                            done_d  = 1'b1;
                            fault_d = 1'b1;
                            fcode_d = 2'b10;
                        end else begin
                            state_d = S_READ;
                            re_d    = 1'b1;
                            addr_d  = sp_q;
                        end
                    end
                end
            end
            S_WRITE: begin
                sp_d = sp_q + ADDR_W'(1);
                if (cnt_q != '0) begin
                    we_d    = 1'b1;
                    addr_d  = sp_q + ADDR_W'(2);
                    wdata_d = wsh_q[DATA_W-1:0];
                    wsh_d   = wsh_q >> DATA_W;
                    cnt_d   = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    if (!single_q) begin
                        pcload_d = 1'b1;
                        pc_out_d = tgt_q;
                    end
                end
            end
            S_READ: begin
                sp_d = sp_q - ADDR_W'(1);
                if (cnt_q != '0) begin
                    re_d   = 1'b1;
                    addr_d = sp_q - ADDR_W'(1);
                    cnt_d  = cnt_q - CNT_W'(1);
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last read word lands now; asm_d already includes it.
                state_d = S_DONE;
                done_d  = 1'b1;
                if (single_q) begin
                    pop_d = asm_d[DATA_W-1:0];
                end else begin
                    pcload_d = 1'b1;
                    pc_out_d = asm_d;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_FAULT: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    // Datapath and registered outputs; reset abandons any partial operation.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sp_q      <= SP_EMPTY;
            cnt_q     <= '0;
            single_q  <= 1'b0;
            tgt_q     <= '0;
            wsh_q     <= '0;
            asm_q     <= '0;
            rd_pend_q <= 1'b0;
            done_q    <= 1'b0;
            pcload_q  <= 1'b0;
            fault_q   <= 1'b0;
            fcode_q   <= 2'b00;
            pc_out_q  <= '0;
            pop_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            cnt_q     <= cnt_d;
            single_q  <= single_d;
            tgt_q     <= tgt_d;
            wsh_q     <= wsh_d;
            asm_q     <= asm_d;
            rd_pend_q <= re_q;
            done_q    <= done_d;
            pcload_q  <= pcload_d;
            fault_q   <= fault_d;
            fcode_q   <= fcode_d;
            pc_out_q  <= pc_out_d;
            pop_q     <= pop_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            re_q      <= re_d;
        end
    end

    assign busy_o       = (state_q != S_IDLE);
    assign done_o       = done_q;
    assign pc_load_o    = pcload_q;
    assign pc_o         = pc_out_q;
    assign pop_data_o   = pop_q;
    assign fault_o      = fault_q;
    assign fault_code_o = fcode_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_we_o     = we_q;
    assign mem_re_o     = re_q;
    assign sp_o         = sp_q;

endmodule
